rvm_mem_arbiter: RTL

Arbitrates the core's single memory port between the fetch path (read-only) and the load/store path (read/write). Each requester sees a simple req/done handshake. The arbiter owns the `mem_*` pins and sequences each access through a 3-state FSM. It applies round-robin fairness under contention and a stall timeout that turns a hung access into an error response. It sits between `rvm_control` and the external memory interface.

---
 rtl/rvm_mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rvm_mem_arbiter.sv
// Shares the single memory port between fetch (read-only) and load/store.
// Round-robin on contention; a stall timeout converts a hung access into an error response.
module rvm_mem_arbiter #(
  parameter int STALL_LIMIT = 16,
  parameter int STALL_W     = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_wen,
  input  logic [3:0]  d_ben,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic        mem_w_en,
  output logic [3:0]  mem_b_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_stall
);

  // state | meaning
  // IDLE  | no access; requests are sampled and arbitrated
  // BUSY  | latched access on the mem_* pins, waiting out stalls
  // RESP  | winner's done pulses for one cycle
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit               TIMEOUT_EN = (STALL_LIMIT != 0);
  localparam logic [STALL_W-1:0] LIM_M1   = STALL_W'(STALL_LIMIT - 1);

  state_t             state_q, state_d;
  logic               last_d_q, win_d_q;
  logic [STALL_W-1:0] cnt_q;
  logic [31:0]        lat_addr, lat_wdata;
  logic               lat_wen;
  logic [3:0]         lat_ben;
  logic               grant, grant_d, complete, stall_abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_d     = 1'b0;
    complete    = 1'b0;
    stall_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          grant   = 1'b1;
          // contention goes to whoever did not win last time
          grant_d = d_req && (!f_req || !last_d_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!mem_stall) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (TIMEOUT_EN && cnt_q == LIM_M1) begin
          stall_abort = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_d_q  <= 1'b1;
      win_d_q   <= 1'b0;
      cnt_q     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wen   <= 1'b0;
      lat_ben   <= '0;
      f_rdata   <= '0;
      f_error   <= 1'b0;
      d_rdata   <= '0;
      d_error   <= 1'b0;
    end else begin
      if (grant) begin
        lat_addr  <= grant_d ? d_addr : f_addr;
        lat_wdata <= grant_d ? d_wdata : 32'h0;
        lat_wen   <= grant_d & d_wen;
        lat_ben   <= grant_d ? d_ben : 4'hF;
        win_d_q   <= grant_d;
        last_d_q  <= grant_d;
        cnt_q     <= '0;
      end
      if (state_q == BUSY && mem_stall && !stall_abort)
        cnt_q <= cnt_q + STALL_W'(1);
      if (complete || stall_abort) begin
        if (win_d_q) begin
          d_rdata <= complete ? mem_rdata : 32'h0;
          d_error <= complete ? mem_error : 1'b1;
        end else begin
          f_rdata <= complete ? mem_rdata : 32'h0;
          f_error <= complete ? mem_error : 1'b1;
        end
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign f_done    = (state_q == RESP) && !win_d_q;
  assign d_done    = (state_q == RESP) && win_d_q;
  assign mem_c_en  = (state_q == BUSY);
  assign mem_addr  = mem_c_en ? lat_addr  : 32'h0;
  assign mem_wdata = mem_c_en ? lat_wdata : 32'h0;
  assign mem_w_en  = mem_c_en & lat_wen;
  assign mem_b_en  = mem_c_en ? lat_ben   : 4'h0;

endmodule
